// File: rtl/mt32_cfg_arbiter_if.sv
// Requester and MT32-pi slave signals of the configuration arbiter.
// The arbiter side is the slave modport; sources and the Pi model drive the master side.
interface mt32_cfg_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int OWN_W = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_mode;
  logic [2*NREQ-1:0] req_rom;
  logic [8*NREQ-1:0] req_sf;
  logic [NREQ-1:0]   req_ready;
  logic              mt32_available;
  logic              mt32_newmode;
  logic [7:0]        mt32_mode;
  logic [7:0]        mt32_rom;
  logic [7:0]        mt32_sf;
  logic              mt32_mode_req;
  logic [1:0]        mt32_rom_req;
  logic [7:0]        mt32_sf_req;
  logic              busy;
  logic [OWN_W-1:0]  owner;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_mode, req_rom, req_sf,
    output mt32_available, mt32_newmode, mt32_mode, mt32_rom, mt32_sf,
    input  req_ready, mt32_mode_req, mt32_rom_req, mt32_sf_req,
    input  busy, owner, done, err
  );

  modport slave (
    input  req_valid, req_mode, req_rom, req_sf,
    input  mt32_available, mt32_newmode, mt32_mode, mt32_rom, mt32_sf,
    output req_ready, mt32_mode_req, mt32_rom_req, mt32_sf_req,
    output busy, owner, done, err
  );
endinterface

// File: rtl/mt32_cfg_arbiter.sv
// Round-robin arbiter sequencing MT32-pi configuration requests one at a time,
// confirming each against the Pi's mode report with bounded retries.
module mt32_cfg_arbiter #(
  parameter int NREQ      = 2,
  parameter int OWN_W     = 1,
  parameter int TIMEOUT   = 12288000,
  parameter int TO_W      = 24,
  parameter int MAX_RETRY = 2
) (
  input  logic              CLK_AUDIO,
  input  logic              reset,
  mt32_cfg_arbiter_if.slave cfg
);
  localparam int               RT_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int               CW      = OWN_W + 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [RT_W-1:0]  RT_MAX  = RT_W'(MAX_RETRY);
  localparam logic [OWN_W-1:0] RR_INIT = OWN_W'(NREQ - 1);
  localparam logic [CW-1:0]    NREQ_C  = CW'(NREQ);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

  state_t            state_reg, state_next;
  logic [OWN_W-1:0]  rr_reg, rr_next;
  logic [OWN_W-1:0]  owner_reg, owner_next;
  logic [TO_W-1:0]   timer_reg, timer_next;
  logic [RT_W-1:0]   retry_reg, retry_next;
  logic              nm_d_reg;
  logic [NREQ-1:0]   ready_reg, ready_next;
  logic              mode_req_reg, mode_req_next;
  logic [1:0]        rom_req_reg, rom_req_next;
  logic [7:0]        sf_req_reg, sf_req_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic [1:0] rom_slice [NREQ];
  logic [7:0] sf_slice  [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign rom_slice[gi] = cfg.req_rom[2*gi +: 2];
      assign sf_slice[gi]  = cfg.req_sf[8*gi +: 8];
    end
  endgenerate

  // First pending requester strictly after the last winner, wrapping around.
  logic             grant_any;
  logic [OWN_W-1:0] grant_idx;
  logic [CW-1:0]    cand;
  logic [OWN_W-1:0] cand_idx;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_reg} + CW'(k);
      if (cand >= NREQ_C) cand = cand - NREQ_C;
      cand_idx = cand[OWN_W-1:0];
      if (!grant_any && cfg.req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  logic toggle;
  logic cfg_match;

  assign toggle    = nm_d_reg ^ cfg.mt32_newmode;
  assign cfg_match = mode_req_reg ? (cfg.mt32_mode == 8'h01 && cfg.mt32_sf == sf_req_reg)
                                  : (cfg.mt32_mode == 8'h00 && cfg.mt32_rom == {6'd0, rom_req_reg});

  always_comb begin
    state_next    = state_reg;
    rr_next       = rr_reg;
    owner_next    = owner_reg;
    timer_next    = timer_reg;
    retry_next    = retry_reg;
    ready_next    = '0;
    mode_req_next = mode_req_reg;
    rom_req_next  = rom_req_reg;
    sf_req_next   = sf_req_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cfg.mt32_available && grant_any) begin
          ready_next[grant_idx] = 1'b1;
          mode_req_next = cfg.req_mode[grant_idx];
          rom_req_next  = rom_slice[grant_idx];
          sf_req_next   = sf_slice[grant_idx];
          owner_next    = grant_idx;
          rr_next       = grant_idx;
          busy_next     = 1'b1;
          timer_next    = '0;
          retry_next    = '0;
          state_next    = WAIT;
        end
      end

      // Pi loss beats a report, and a report beats an expiring window.
      WAIT: begin
        if (!cfg.mt32_available) begin
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (toggle) begin
          state_next = CHECK;
        end else if (timer_reg == TO_LAST) begin
          if (retry_reg < RT_MAX) begin
            retry_next = retry_reg + RT_W'(1);
            timer_next = '0;
          end else begin
            err_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end else begin
          timer_next = timer_reg + TO_W'(1);
        end
      end

      CHECK: begin
        if (cfg_match) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (retry_reg < RT_MAX) begin
          retry_next = retry_reg + RT_W'(1);
          timer_next = '0;
          state_next = WAIT;
        end else begin
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // The newmode history keeps sampling through reset so no stale edge survives it.
  always_ff @(posedge CLK_AUDIO) begin
    nm_d_reg <= cfg.mt32_newmode;
    if (reset) begin
      state_reg    <= IDLE;
      rr_reg       <= RR_INIT;
      owner_reg    <= '0;
      timer_reg    <= '0;
      retry_reg    <= '0;
      ready_reg    <= '0;
      mode_req_reg <= 1'b0;
      rom_req_reg  <= '0;
      sf_req_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_reg       <= rr_next;
      owner_reg    <= owner_next;
      timer_reg    <= timer_next;
      retry_reg    <= retry_next;
      ready_reg    <= ready_next;
      mode_req_reg <= mode_req_next;
      rom_req_reg  <= rom_req_next;
      sf_req_reg   <= sf_req_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign cfg.req_ready     = ready_reg;
  assign cfg.mt32_mode_req = mode_req_reg;
  assign cfg.mt32_rom_req  = rom_req_reg;
  assign cfg.mt32_sf_req   = sf_req_reg;
  assign cfg.busy          = busy_reg;
  assign cfg.owner         = owner_reg;
  assign cfg.done          = done_reg;
  assign cfg.err           = err_reg;
endmodule

// File: tb/tb_mt32_cfg_arbiter.sv
// Randomized bench for mt32_cfg_arbiter against a transaction-level model of
// round-robin grants, match rules and retry/timeout windows.
module tb_mt32_cfg_arbiter;
  localparam int NREQ = 2;
  localparam int TOUT = 16;
  localparam int MAXR = 2;

  logic CLK_AUDIO = 1'b0;
  logic reset     = 1'b1;
  always #5 CLK_AUDIO = ~CLK_AUDIO;

  mt32_cfg_arbiter_if #(.NREQ(NREQ), .OWN_W(1)) bus ();

  mt32_cfg_arbiter #(.NREQ(NREQ), .OWN_W(1), .TIMEOUT(TOUT), .TO_W(5), .MAX_RETRY(MAXR)) dut (
    .CLK_AUDIO (CLK_AUDIO),
    .reset     (reset),
    .cfg       (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, ack_cnt = 0;
  int grants_m = 0, finished_m = 0, rr_m = NREQ - 1;
  logic nm = 1'b0;
  logic       mode_m [NREQ];
  logic [1:0] rom_m  [NREQ];
  logic [7:0] sf_m   [NREQ];

  function automatic int next_owner(input logic [NREQ-1:0] pend, input int last);
    next_owner = -1;
    for (int k = 1; k <= NREQ; k++)
      if (next_owner < 0 && pend[(last + k) % NREQ]) next_owner = (last + k) % NREQ;
  endfunction

  task automatic tick();
    @(negedge CLK_AUDIO);
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
    if (bus.done && bus.err) both_cnt++;
    if (bus.req_ready != '0) ack_cnt++;
    bus.req_valid = bus.req_valid & ~bus.req_ready;
  endtask

  task automatic set_req(input int i, input logic m, input logic [1:0] r, input logic [7:0] s);
    bus.req_mode[i] = m;
    bus.req_rom[2*i +: 2] = r;
    bus.req_sf[8*i +: 8] = s;
    bus.req_valid[i] = 1'b1;
    mode_m[i] = m; rom_m[i] = r; sf_m[i] = s;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wait_ready(output int who);
    who = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.req_ready != '0) begin
        who = -2;
        for (int j = 0; j < NREQ; j++) if (bus.req_ready == NREQ'(1 << j)) who = j;
        break;
      end
    end
  endtask

  // kind: 0 none within budget, 1 done, 2 err; cyc counts sampled cycles.
  task automatic wait_outcome(input int budget, output int cyc, output int kind);
    kind = 0; cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (bus.done || bus.err) begin
        cyc = c; kind = bus.done ? 1 : 2;
        break;
      end
    end
  endtask

  task automatic respond(input int i, input bit ok);
    logic [7:0] flip;
    flip = 8'(1 << $urandom_range(0, 7));
    if (mode_m[i] == 1'b0) begin
      bus.mt32_mode = 8'h00; bus.mt32_rom = {6'd0, rom_m[i]}; bus.mt32_sf = 8'($urandom);
      if (!ok) begin
        if ($urandom_range(0, 1) == 0) bus.mt32_mode = 8'h01;
        else bus.mt32_rom = bus.mt32_rom ^ flip;
      end
    end else begin
      bus.mt32_mode = 8'h01; bus.mt32_sf = sf_m[i]; bus.mt32_rom = 8'($urandom);
      if (!ok) begin
        if ($urandom_range(0, 1) == 0) bus.mt32_mode = 8'h00;
        else bus.mt32_sf = bus.mt32_sf ^ flip;
      end
    end
    nm = ~nm;
    bus.mt32_newmode = nm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({bus.req_ready, bus.mt32_mode_req, bus.mt32_rom_req, bus.mt32_sf_req, bus.busy, bus.owner, bus.done, bus.err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got ready=%b busy=%b owner=%0d done=%b err=%b, want all 0",
                        bus.req_ready, bus.busy, bus.owner, bus.done, bus.err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int who, cyc, kind, exp;
    bus.mt32_available = 1'b1;
    set_req(0, 1'b0, 2'd1, 8'($urandom));
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    $display("single: grant %0d", who);
    n_cmp++; if (who !== exp) begin n_bad++; $display("FAIL single_grant: got %0d want %0d", who, exp); end
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
    n_cmp++;
    if ({bus.mt32_mode_req, bus.mt32_rom_req, bus.busy, bus.owner} !== {1'b0, 2'd1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL single_fields: got mode=%b rom=%0d busy=%b owner=%0d want 0 1 1 0",
                        bus.mt32_mode_req, bus.mt32_rom_req, bus.busy, bus.owner);
    end
    respond(0, 1'b1);
    wait_outcome(50, cyc, kind);
    finished_m++;
    n_cmp++;
    if (kind !== 1 || cyc !== 2 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got kind=%0d cyc=%0d busy=%b err=%b want done at 2, busy 0", kind, cyc, bus.busy, bus.err);
    end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL single_pulse: done still %b after one cycle", bus.done); end
  endtask

  task automatic test_round_robin();
    int who, cyc, kind, exp;
    bit first1;
    first1 = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i]) begin
          if (i == 1 && first1) begin set_req(1, 1'b1, 2'($urandom), 8'h05); first1 = 1'b0; end
          else set_rand_req(i);
        end
      end
      exp = next_owner(bus.req_valid, rr_m);
      wait_ready(who);
      grants_m++; rr_m = exp;
      $display("rr: round %0d grant %0d mode=%b rom=%0d sf=%02h", n, who, bus.mt32_mode_req, bus.mt32_rom_req, bus.mt32_sf_req);
      n_cmp++;
      if (who !== exp || bus.owner !== 1'(exp)) begin
        n_bad++; $display("FAIL rr_grant: got who=%0d owner=%0d want %0d", who, bus.owner, exp);
      end
      n_cmp++;
      if ({bus.mt32_mode_req, bus.mt32_rom_req, bus.mt32_sf_req} !== {mode_m[exp], rom_m[exp], sf_m[exp]}) begin
        n_bad++; $display("FAIL rr_payload: got %b/%0d/%02h want %b/%0d/%02h", bus.mt32_mode_req, bus.mt32_rom_req,
                          bus.mt32_sf_req, mode_m[exp], rom_m[exp], sf_m[exp]);
      end
      repeat ($urandom_range(0, 4)) tick();
      respond(exp, 1'b1);
      wait_outcome(50, cyc, kind);
      finished_m++;
      n_cmp++; if (kind !== 1 || cyc !== 2) begin n_bad++; $display("FAIL rr_done: got kind=%0d cyc=%0d want done at 2", kind, cyc); end
    end
    while (bus.req_valid != '0) begin
      exp = next_owner(bus.req_valid, rr_m);
      wait_ready(who);
      grants_m++; rr_m = exp;
      respond(exp, 1'b1);
      wait_outcome(50, cyc, kind);
      finished_m++;
      n_cmp++; if (who !== exp || kind !== 1) begin n_bad++; $display("FAIL rr_drain: got who=%0d kind=%0d want %0d done", who, kind, exp); end
    end
  endtask

  task automatic test_timeout();
    int who, cyc, kind, i, exp;
    i = $urandom_range(0, NREQ - 1);
    set_rand_req(i);
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    wait_outcome(200, cyc, kind);
    finished_m++;
    $display("timeout: grant %0d outcome %0d after %0d cycles", who, kind, cyc);
    n_cmp++;
    if (kind !== 2 || cyc !== TOUT * (1 + MAXR) || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL timeout_err: got kind=%0d cyc=%0d busy=%b want err at %0d", kind, cyc, bus.busy, TOUT * (1 + MAXR));
    end
    n_cmp++;
    if ({bus.mt32_mode_req, bus.mt32_rom_req, bus.mt32_sf_req} !== {mode_m[exp], rom_m[exp], sf_m[exp]}) begin
      n_bad++; $display("FAIL timeout_hold: request fields %b/%0d/%02h not held", bus.mt32_mode_req, bus.mt32_rom_req, bus.mt32_sf_req);
    end
    // A report arriving on the very last cycle of the final window must still confirm.
    set_rand_req(i);
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    repeat (TOUT * (1 + MAXR) - 1) tick();
    respond(exp, 1'b1);
    wait_outcome(10, cyc, kind);
    finished_m++;
    $display("toggle_vs_timeout: outcome %0d after %0d cycles", kind, cyc);
    n_cmp++; if (kind !== 1 || cyc !== 2) begin n_bad++; $display("FAIL toggle_vs_timeout: got kind=%0d cyc=%0d want done at 2", kind, cyc); end
  endtask

  task automatic test_mismatch();
    int who, cyc, kind, i, exp, e0, d0;
    i = $urandom_range(0, NREQ - 1);
    set_req(i, 1'b0, 2'd1, 8'($urandom));
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    e0 = err_cnt; d0 = done_cnt;
    respond(exp, 1'b0);
    repeat (2) tick();
    n_cmp++;
    if (err_cnt !== e0 || done_cnt !== d0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL mismatch_retry: got err=%0d done=%0d busy=%b want no pulse, busy 1", err_cnt - e0, done_cnt - d0, bus.busy);
    end
    repeat ($urandom_range(0, 5)) tick();
    respond(exp, 1'b1);
    wait_outcome(20, cyc, kind);
    finished_m++;
    $display("mismatch_then_match: outcome %0d after %0d cycles", kind, cyc);
    n_cmp++; if (kind !== 1 || cyc !== 2) begin n_bad++; $display("FAIL mismatch_match: got kind=%0d cyc=%0d want done at 2", kind, cyc); end

    set_rand_req(i);
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    e0 = err_cnt; d0 = done_cnt;
    for (int m = 0; m < MAXR; m++) begin
      respond(exp, 1'b0);
      repeat (2 + $urandom_range(0, 3)) tick();
    end
    n_cmp++;
    if (err_cnt !== e0 || done_cnt !== d0) begin
      n_bad++; $display("FAIL mismatch_early: got err=%0d done=%0d during retries, want 0", err_cnt - e0, done_cnt - d0);
    end
    respond(exp, 1'b0);
    wait_outcome(20, cyc, kind);
    finished_m++;
    $display("mismatch_exhaust: outcome %0d after %0d cycles", kind, cyc);
    n_cmp++; if (kind !== 2 || cyc !== 2) begin n_bad++; $display("FAIL mismatch_exhaust: got kind=%0d cyc=%0d want err at 2", kind, cyc); end
  endtask

  task automatic test_pi_lost();
    int who, cyc, kind, a, b, exp, a0;
    a = $urandom_range(0, NREQ - 1);
    b = (a + 1) % NREQ;
    set_rand_req(a);
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    a0 = ack_cnt;
    set_rand_req(b);
    repeat ($urandom_range(1, 10)) tick();
    bus.mt32_available = 1'b0;
    respond(exp, 1'b1);
    wait_outcome(5, cyc, kind);
    finished_m++;
    $display("pi_lost: outcome %0d after %0d cycles", kind, cyc);
    n_cmp++; if (kind !== 2 || cyc !== 1) begin n_bad++; $display("FAIL pi_lost_err: got kind=%0d cyc=%0d want err at 1", kind, cyc); end
    repeat (6) tick();
    n_cmp++;
    if (ack_cnt !== a0 || bus.req_valid[b] !== 1'b1) begin
      n_bad++; $display("FAIL pi_lost_pending: got %0d acks while busy/unavailable, want 0", ack_cnt - a0);
    end
    bus.mt32_available = 1'b1;
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    n_cmp++; if (who !== exp) begin n_bad++; $display("FAIL pi_back_grant: got %0d want %0d", who, exp); end
    respond(exp, 1'b1);
    wait_outcome(20, cyc, kind);
    finished_m++;
    n_cmp++; if (kind !== 1) begin n_bad++; $display("FAIL pi_back_done: got kind=%0d want done", kind); end
  endtask

  task automatic test_reset_mid();
    int who, cyc, kind, exp, e0, d0;
    set_rand_req(0);
    exp = next_owner(bus.req_valid, rr_m);
    wait_ready(who);
    grants_m++; rr_m = exp;
    repeat ($urandom_range(1, 8)) tick();
    e0 = err_cnt; d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr_m = NREQ - 1;
    n_cmp++;
    if ({bus.req_ready, bus.mt32_mode_req, bus.mt32_rom_req, bus.mt32_sf_req, bus.busy, bus.owner, bus.done, bus.err} !== '0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got busy=%b owner=%0d rom=%0d sf=%02h, want all 0",
                        bus.busy, bus.owner, bus.mt32_rom_req, bus.mt32_sf_req);
    end
    respond(0, 1'b1);
    repeat (4) tick();
    n_cmp++;
    if (err_cnt !== e0 || done_cnt !== d0) begin
      n_bad++; $display("FAIL reset_mid_pulse: got done=%0d err=%0d after abort, want 0", done_cnt - d0, err_cnt - e0);
    end
    set_rand_req(0);
    set_rand_req(1);
    for (int n = 0; n < NREQ; n++) begin
      exp = next_owner(bus.req_valid, rr_m);
      wait_ready(who);
      grants_m++; rr_m = exp;
      $display("reset_mid: grant %0d", who);
      n_cmp++; if (who !== exp) begin n_bad++; $display("FAIL reset_mid_grant: got %0d want %0d", who, exp); end
      respond(exp, 1'b1);
      wait_outcome(20, cyc, kind);
      finished_m++;
      n_cmp++; if (kind !== 1) begin n_bad++; $display("FAIL reset_mid_done: got kind=%0d want done", kind); end
    end
  endtask

  initial begin
    bus.req_valid = '0; bus.req_mode = '0; bus.req_rom = '0; bus.req_sf = '0;
    bus.mt32_available = 1'b0; bus.mt32_newmode = 1'b0;
    bus.mt32_mode = 8'h00; bus.mt32_rom = 8'h00; bus.mt32_sf = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_mismatch();
    test_pi_lost();
    test_reset_mid();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL done_err_overlap: %0d cycles with both high", both_cnt); end
    n_cmp++;
    if (done_cnt + err_cnt !== finished_m) begin
      n_bad++; $display("FAIL pulse_count: got %0d done+err pulses want %0d", done_cnt + err_cnt, finished_m);
    end
    n_cmp++; if (ack_cnt !== grants_m) begin n_bad++; $display("FAIL ack_count: got %0d acks want %0d", ack_cnt, grants_m); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
